// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin arbiter sharing one synchronous sprite/tile ROM
// between the layer fetchers, with in-flight tracking and per-owner read-data return.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 3,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      busy
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [ID_W-1:0]    win_id;

  logic [ROM_LAT:0]   pipe_valid;
  logic [ID_W-1:0]    pipe_id [0:ROM_LAT];

  // A requester granted this cycle is masked so a held req waits one cycle.
  always_comb begin
    eligible  = req & ~gnt;
    win_found = 1'b0;
    win_id    = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign busy = |pipe_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= '0;
      rvalid     <= '0;
      rdata      <= '0;
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      ptr        <= ID_W'(NUM_REQ - 1);
      pipe_valid <= '0;
      for (int k = 0; k <= ROM_LAT; k++) pipe_id[k] <= '0;
    end else begin
      gnt    <= '0;
      rom_en <= win_found;
      if (win_found) begin
        gnt[win_id] <= 1'b1;
        rom_addr    <= addr[win_id*ADDR_W +: ADDR_W];
        ptr         <= win_id;
      end

      // Stage k holds the read issued k cycles ago; the last stage lines up with rom_data.
      pipe_valid <= {pipe_valid[ROM_LAT-1:0], win_found};
      pipe_id[0] <= win_id;
      for (int k = 1; k <= ROM_LAT; k++) pipe_id[k] <= pipe_id[k-1];

      rvalid <= '0;
      if (pipe_valid[ROM_LAT]) begin
        rvalid[pipe_id[ROM_LAT]] <= 1'b1;
        rdata                    <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - self-checking bench for sprite_rom_arbiter
// (directed vector table plus contention and mid-flight reset sequences).
module tb_sprite_rom_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] addr;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [2:0]  rdata;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [2:0]  rom_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sprite_rom_arbiter #(.NUM_REQ(3), .ADDR_W(8), .DATA_W(3), .ROM_LAT(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] rom_fn(input logic [7:0] a);
    return a[2:0] - 3'd1;
  endfunction

  // One-cycle-latency synchronous ROM
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_fn(rom_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [2:0] rvalid;
    logic [2:0] rdata;
    logic       busy;
    logic       rom_en;
    logic [7:0] rom_addr;
  } vec_t;

  vec_t vecs [0:22];

  logic [2:0] exp_g    [0:13];
  logic [2:0] exp_d    [0:13];
  int         gcount   [0:2];

  initial begin
    // rst, req, gnt, rvalid, rdata, busy, rom_en, rom_addr   (addr = {33,2A,10})
    vecs[0]  = '{1'b1, 3'b111, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 3'b101, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 3'b111, 3'b001, 3'b000, 3'd0, 1'b1, 1'b1, 8'h10};
    vecs[3]  = '{1'b0, 3'b111, 3'b010, 3'b000, 3'd0, 1'b1, 1'b1, 8'h2A};
    vecs[4]  = '{1'b0, 3'b111, 3'b100, 3'b001, 3'd7, 1'b1, 1'b1, 8'h33};
    vecs[5]  = '{1'b0, 3'b111, 3'b001, 3'b010, 3'd1, 1'b1, 1'b1, 8'h10};
    vecs[6]  = '{1'b0, 3'b000, 3'b000, 3'b100, 3'd2, 1'b1, 1'b0, 8'h10};
    vecs[7]  = '{1'b0, 3'b000, 3'b000, 3'b001, 3'd7, 1'b0, 1'b0, 8'h10};
    vecs[8]  = '{1'b0, 3'b000, 3'b000, 3'b000, 3'd7, 1'b0, 1'b0, 8'h10};
    vecs[9]  = '{1'b0, 3'b010, 3'b010, 3'b000, 3'd7, 1'b1, 1'b1, 8'h2A};
    vecs[10] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'd7, 1'b1, 1'b0, 8'h2A};
    vecs[11] = '{1'b0, 3'b000, 3'b000, 3'b010, 3'd1, 1'b0, 1'b0, 8'h2A};
    vecs[12] = '{1'b0, 3'b100, 3'b100, 3'b000, 3'd1, 1'b1, 1'b1, 8'h33};
    vecs[13] = '{1'b0, 3'b100, 3'b000, 3'b000, 3'd1, 1'b1, 1'b0, 8'h33};
    vecs[14] = '{1'b0, 3'b100, 3'b100, 3'b100, 3'd2, 1'b1, 1'b1, 8'h33};
    vecs[15] = '{1'b0, 3'b100, 3'b000, 3'b000, 3'd2, 1'b1, 1'b0, 8'h33};
    vecs[16] = '{1'b0, 3'b000, 3'b000, 3'b100, 3'd2, 1'b0, 1'b0, 8'h33};
    vecs[17] = '{1'b0, 3'b001, 3'b001, 3'b000, 3'd2, 1'b1, 1'b1, 8'h10};
    vecs[18] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'd2, 1'b1, 1'b0, 8'h10};
    vecs[19] = '{1'b0, 3'b011, 3'b010, 3'b001, 3'd7, 1'b1, 1'b1, 8'h2A};
    vecs[20] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'd7, 1'b1, 1'b0, 8'h2A};
    vecs[21] = '{1'b0, 3'b000, 3'b000, 3'b010, 3'd1, 1'b0, 1'b0, 8'h2A};
    vecs[22] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'd1, 1'b0, 1'b0, 8'h2A};

    rst      = 1'b1;
    req      = 3'b000;
    addr     = {8'h33, 8'h2A, 8'h10};
    rom_data = 3'd0;

    for (int i = 0; i <= 22; i++) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d gnt", i),      32'(gnt),      32'(vecs[i].gnt));
      chk($sformatf("v%0d rvalid", i),   32'(rvalid),   32'(vecs[i].rvalid));
      chk($sformatf("v%0d rdata", i),    32'(rdata),    32'(vecs[i].rdata));
      chk($sformatf("v%0d busy", i),     32'(busy),     32'(vecs[i].busy));
      chk($sformatf("v%0d rom_en", i),   32'(rom_en),   32'(vecs[i].rom_en));
      chk($sformatf("v%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].rom_addr));
    end

    // Contention: last grant was requester 1, so rotation starts at 2.
    addr = {8'h67, 8'h5E, 8'h45};
    for (int i = 0; i < 3; i++) gcount[i] = 0;
    for (int c = 0; c < 14; c++) begin
      int w;
      req = (c < 12) ? 3'b111 : 3'b000;
      @(posedge clk);
      #1;
      w = (2 + c) % 3;
      exp_g[c] = (c < 12) ? 3'(1 << w) : 3'b000;
      exp_d[c] = rom_fn(addr[w*8 +: 8]);
      chk($sformatf("cont%0d gnt", c), 32'(gnt), 32'(exp_g[c]));
      if (c < 12) chk($sformatf("cont%0d rom_addr", c), 32'(rom_addr), 32'(addr[w*8 +: 8]));
      for (int i = 0; i < 3; i++) if (gnt[i]) gcount[i]++;
      if (c < 2) begin
        chk($sformatf("cont%0d rvalid", c), 32'(rvalid), 32'(0));
      end else begin
        chk($sformatf("cont%0d rvalid", c), 32'(rvalid), 32'(exp_g[c-2]));
        chk($sformatf("cont%0d rdata", c),  32'(rdata),  32'(exp_d[c-2]));
      end
    end
    for (int i = 0; i < 3; i++) chk($sformatf("cont count%0d", i), 32'(gcount[i]), 32'd4);
    req = 3'b000;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the cycle after a grant discards the in-flight read.
    addr = {8'h33, 8'h2A, 8'h10};
    req  = 3'b001;
    @(posedge clk);
    #1;
    chk("rst grant", 32'(gnt), 32'b001);
    req = 3'b000;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rvalid", 32'(rvalid), 32'd0);
    chk("rst gnt", 32'(gnt), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst hold%0d rvalid", c), 32'(rvalid), 32'd0);
    end
    rst = 1'b0;
    req = 3'b111;
    @(posedge clk);
    #1;
    chk("post rst gnt0", 32'(gnt), 32'b001);
    chk("post rst rvalid0", 32'(rvalid), 32'd0);
    @(posedge clk);
    #1;
    chk("post rst gnt1", 32'(gnt), 32'b010);
    chk("post rst rvalid1", 32'(rvalid), 32'd0);
    req = 3'b000;
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
